obi_arbiter_2to1: RTL
=====================

# obi_arbiter_2to1

Two-manager to one-subordinate OBI arbiter for the fabric's OBI peripheral port. Two user-design OBI managers (M0, M1) share a single subordinate channel (S) with a 24-bit address, 32-bit data and 4-bit byte enables. The arbiter selects one request per cycle, locks the selection until it is granted, and records the winner's ID in an in-order FIFO so each S response returns to the correct manager. It sits between fabric-side user logic and the OBI peripheral primitive.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions. Power of two, 1..8.
- `UserCLK` input 1: the single clock. All state updates on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `M0_REQ`, `M1_REQ` input 1: manager address-phase requests.
- `M0_WE`, `M1_WE` input 1: write enables.
- `M0_BE`, `M1_BE` input 4: byte enables.
- `M0_ADDR`, `M1_ADDR` input 24: addresses.
- `M0_WDATA`, `M1_WDATA` input 32: write data.
- `M0_GNT`, `M1_GNT` output 1: grants to the managers.
- `M0_RVALID`, `M1_RVALID` output 1: response valids to the managers.
- `M0_RDATA`, `M1_RDATA` output 32: read data to the managers.
- `S_REQ`, `S_WE` output 1: subordinate request and write enable.
- `S_BE` output 4: subordinate byte enables.
- `S_ADDR` output 24: subordinate address.
- `S_WDATA` output 32: subordinate write data.
- `S_GNT`, `S_RVALID` input 1: subordinate grant and response valid.
- `S_RDATA` input 32: subordinate read data.
- `ERR` output 1: sticky flag. Set when `S_RVALID` arrives while the ID FIFO is empty. Cleared only by `RST`.

## Operation
- **Selection `sel`.**
  - When `locked` is 1, `sel` = `lock_id`.
  - Otherwise, if exactly one manager requests, that manager wins.
  - If both request, the tie-break rule applies (see Configuration).
- **Address mux.**
  - `S_REQ` = (`M0_REQ` | `M1_REQ`) & !full.
  - `S_WE`, `S_BE`, `S_ADDR` and `S_WDATA` come from `sel`. They are don't-care when `S_REQ` = 0.
- **Grant.** `Mx_GNT` = `S_GNT` & `S_REQ` & (`sel` == x). The other manager's GNT is 0.
- **Lock.**
  - If `S_REQ` = 1 and `S_GNT` = 0, then next cycle `locked` = 1 and `lock_id` = `sel`.
  - `locked` clears on the cycle the locked request is granted.
  - This keeps the address phase stable while S stalls, as OBI requires.
- **ID FIFO.**
  - Depth `MAX_OUTSTANDING`, 1 bit wide, with a count register of width clog2(`MAX_OUTSTANDING`)+1.
  - Push `sel` on an accepted transaction (`S_REQ` & `S_GNT`).
  - Pop on `S_RVALID` when the FIFO is not empty.
  - full = (count == `MAX_OUTSTANDING`). While full, `S_REQ` = 0, so no push occurs, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- **Response routing.**
  - `Mx_RVALID` = `S_RVALID` & !empty & (FIFO head == x).
  - `M0_RDATA` and `M1_RDATA` are both driven directly by `S_RDATA`.
- **Stray response.** `S_RVALID` while empty: nothing is routed, `ERR` sets, the FIFO is unchanged.

## Timing
- Reset values:
  - `locked` = 0, `lock_id` = 0, FIFO count, head and tail pointers = 0, `ERR` = 0.
  - Round-robin priority pointer = M0 first.
  - Consequently every `Mx_GNT`, `Mx_RVALID` and `S_REQ` is 0 while `RST` is high.
- The address path is combinational with zero added latency: `M_REQ` → `S_REQ` and `S_GNT` → `M_GNT` in the same cycle.
- The response path is combinational with zero added latency: `S_RVALID` → `Mx_RVALID` in the same cycle.
- The earliest possible response is the cycle after the grant. The FIFO pushes at the clock edge, so a same-cycle `S_RVALID` sees the pre-push state.
- Reset mid-operation:
  - Outstanding IDs are discarded.
  - Later `S_RVALID` pulses for those transactions set `ERR` and are not forwarded.
- Throughput: one grant per cycle. `MAX_OUTSTANDING` back-to-back grants are allowed before stalling.

## Configuration
- **`OBI_ARB_ROUND_ROBIN_EN` defined:**
  - Ties are broken by a 1-bit priority pointer.
  - On every accepted transaction, the pointer moves to the manager that was not served.
- **Not defined:**
  - Fixed priority: M0 always wins ties.
  - The pointer register is not present.
- Lock and FIFO behaviour are identical in both builds.

## Test plan
- **Reset and single write.** Hold `RST` 2 cycles. Then M0 write ADDR=0x000010, WDATA=0xDEADBEEF, BE=0xF, with `S_GNT`=1. Required: `S_REQ`=1, `S_ADDR`=0x000010, `M0_GNT`=1 the same cycle. With `S_RVALID` the next cycle: `M0_RVALID`=1, `M1_RVALID`=0.
- **Stall lock.**
  - Setup: M1 requests alone with `S_GNT`=0 for 3 cycles. M0 raises `M0_REQ` in cycle 2.
  - Required: `S_ADDR` stays at M1's address for all stall cycles. On `S_GNT`=1, `M1_GNT`=1 and `M0_GNT`=0. M0 is served next cycle.
- **Tie-break.**
  - Stimulus: both managers request continuously for 4 cycles with `S_GNT`=1.
  - With the macro: grants go M0, M1, M0, M1.
  - Without the macro: grants go M0, M0, M0, M0.
- **Outstanding limit.**
  - Setup: `MAX_OUTSTANDING`=2, `S_RVALID` held 0. M0 issues 3 requests.
  - Required: 2 grants, then `S_REQ`=0 until one `S_RVALID`. The next grant comes the cycle after that pop, not in the pop cycle.
- **Response ordering.**
  - Stimulus: grants in order M1, M0. Responses carry `S_RDATA` 0x11111111 then 0x22222222.
  - Required: the first response gives `M1_RVALID`=1 with `M1_RDATA`=0x11111111. The second gives `M0_RVALID`=1 with `M0_RDATA`=0x22222222.
- **Stray response and reset.** Grant one transaction, assert `RST` for 1 cycle, then pulse `S_RVALID`. Required: no `Mx_RVALID`, `ERR`=1 and held until the next `RST`.

Source files
------------

// File: rtl/obi_arbiter_2to1.sv
// Two-manager to one-subordinate OBI arbiter with address-phase locking and an in-order ID FIFO for response routing.
// Optional build macro OBI_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise M0 wins ties.
module obi_arbiter_2to1 #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        UserCLK,
    input  logic        RST,
    input  logic        M0_REQ,
    input  logic        M0_WE,
    input  logic [3:0]  M0_BE,
    input  logic [23:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_GNT,
    output logic        M0_RVALID,
    output logic [31:0] M0_RDATA,
    input  logic        M1_REQ,
    input  logic        M1_WE,
    input  logic [3:0]  M1_BE,
    input  logic [23:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_GNT,
    output logic        M1_RVALID,
    output logic [31:0] M1_RDATA,
    output logic        S_REQ,
    output logic        S_WE,
    output logic [3:0]  S_BE,
    output logic [23:0] S_ADDR,
    output logic [31:0] S_WDATA,
    input  logic        S_GNT,
    input  logic        S_RVALID,
    input  logic [31:0] S_RDATA,
    output logic        ERR
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       locked_q, locked_d;
    logic                       lock_id_q, lock_id_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [MAX_OUTSTANDING-1:0] fifo_wr_en;
    logic                       err_q, err_d;

    logic sel;
    logic tie_sel;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    assign tie_sel = prio_q;

    // Pointer always moves to the manager that was not just served.
    always_comb begin
        prio_d = prio_q;
        if (push) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign tie_sel = 1'b0;
`endif

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        if (locked_q) begin
            sel = lock_id_q;
        end else if (M0_REQ && M1_REQ) begin
            sel = tie_sel;
        end else begin
            sel = M1_REQ;
        end
    end

    // Requests are masked during reset so nothing leaks out before state is clean.
    assign S_REQ   = (M0_REQ | M1_REQ) & ~full & ~RST;
    assign S_WE    = sel ? M1_WE    : M0_WE;
    assign S_BE    = sel ? M1_BE    : M0_BE;
    assign S_ADDR  = sel ? M1_ADDR  : M0_ADDR;
    assign S_WDATA = sel ? M1_WDATA : M0_WDATA;

    assign push   = S_REQ & S_GNT;
    assign pop    = S_RVALID & ~empty & ~RST;
    assign M0_GNT = push & ~sel;
    assign M1_GNT = push & sel;

    assign M0_RVALID = pop & ~head;
    assign M1_RVALID = pop & head;
    assign M0_RDATA  = S_RDATA;
    assign M1_RDATA  = S_RDATA;
    assign ERR       = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_fifo_wr
            assign fifo_wr_en[gi] = push & (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q | (S_RVALID & empty);

        // Hold the address phase stable while the subordinate stalls.
        if (S_REQ) begin
            if (!S_GNT) begin
                locked_d  = 1'b1;
                lock_id_d = sel;
            end else begin
                locked_d  = 1'b0;
            end
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            locked_q  <= 1'b0;
            lock_id_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
            fifo_q    <= '0;
        end else begin
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (fifo_wr_en[i]) begin
                    fifo_q[i] <= sel;
                end
            end
        end
    end

endmodule
